// File: rtl/if_align_buffer_if.sv
// ============================================================================
// Module   : if_align_buffer_if
// Brief    : Fetch-beat and aligned-instruction handshake bundle for the
//            instruction align buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_align_buffer_if #(
  parameter int FETCH_W = 32,
  parameter int ADDR_W  = 32
);

  // Fetch side: I-cache/MMU beats into the buffer
  logic               fetch_valid_i;
  logic               fetch_ready_o;
  logic [ADDR_W-1:0]  fetch_addr_i;
  logic [FETCH_W-1:0] fetch_data_i;
  logic               fetch_fault_i;

  // Issue side: aligned instructions towards IF/ID
  logic               inst_valid_o;
  logic               inst_ready_i;
  logic [ADDR_W-1:0]  inst_pc_o;
  logic [31:0]        inst_data_o;
  logic               inst_is_rvc_o;
  logic               inst_fault_o;

  modport slave (
    input  fetch_valid_i,
    output fetch_ready_o,
    input  fetch_addr_i,
    input  fetch_data_i,
    input  fetch_fault_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_pc_o,
    output inst_data_o,
    output inst_is_rvc_o,
    output inst_fault_o
  );

  modport master (
    output fetch_valid_i,
    input  fetch_ready_o,
    output fetch_addr_i,
    output fetch_data_i,
    output fetch_fault_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_pc_o,
    input  inst_data_o,
    input  inst_is_rvc_o,
    input  inst_fault_o
  );

endinterface

`default_nettype wire

// File: rtl/if_align_buffer.sv
// ============================================================================
// Module   : if_align_buffer
// Brief    : Halfword fetch queue and RVC/32-bit instruction aligner between
//            the fetch path and IF/ID. Optional counters: IFB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_align_buffer #(
  parameter int FETCH_W  = 32,
  parameter int DEPTH_HW = 8,
  parameter int ADDR_W   = 32
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          flush_i,
  if_align_buffer_if.slave                   bus,
  output logic [$clog2(DEPTH_HW+1)-1:0]      occupancy_o,
  output logic [31:0]                        perf_rvc_cnt_o,
  output logic [31:0]                        perf_bubble_cnt_o
);

  localparam int HWB   = FETCH_W / 16;
  localparam int LB    = $clog2(FETCH_W / 8);
  localparam int OFF_W = LB - 1;
  localparam int PTR_W = $clog2(DEPTH_HW);
  localparam int CNT_W = $clog2(DEPTH_HW + 1);

  logic [15:0]         hw_q [DEPTH_HW];
  logic [15:0]         hw_d [DEPTH_HW];
  logic [ADDR_W-1:0]   pc_q [DEPTH_HW];
  logic [ADDR_W-1:0]   pc_d [DEPTH_HW];
  logic [DEPTH_HW-1:0] fault_q, fault_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   expect_addr_q, expect_addr_d;
  logic                first_beat_q, first_beat_d;

  logic [PTR_W-1:0]    h1_ptr;
  logic [15:0]         h0_hw, h1_hw;
  logic                h0_fault, h1_fault;
  logic                head_rvc;
  logic [CNT_W-1:0]    needed;
  logic                inst_valid;
  logic                inst_pop;

  logic                fetch_ready;
  logic                beat_accept;
  logic                discont;
  logic [OFF_W-1:0]    beat_off;
  logic [ADDR_W-1:0]   beat_base;
  logic [CNT_W-1:0]    push_cnt;
  logic [PTR_W-1:0]    slot;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = bus.fetch_addr_i[0];

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  assign h1_ptr   = rd_ptr_q + PTR_W'(1);
  assign h0_hw    = hw_q[rd_ptr_q];
  assign h1_hw    = hw_q[h1_ptr];
  assign h0_fault = fault_q[rd_ptr_q];
  assign h1_fault = fault_q[h1_ptr];
  assign head_rvc = (h0_hw[1:0] != 2'b11);

  // A faulting lower half is reported on its own; its partner may never arrive.
  assign needed     = (head_rvc || h0_fault) ? CNT_W'(1) : CNT_W'(2);
  assign inst_valid = (count_q >= needed) && !flush_i;
  assign inst_pop   = inst_valid && bus.inst_ready_i;

  assign bus.inst_valid_o  = inst_valid;
  assign bus.inst_pc_o     = pc_q[rd_ptr_q];
  assign bus.inst_data_o   = head_rvc ? {16'h0000, h0_hw} : {h1_hw, h0_hw};
  assign bus.inst_is_rvc_o = head_rvc;
  assign bus.inst_fault_o  = h0_fault || (!head_rvc && h1_fault);

  // --------------------------------------------------------------------------
  // Beat acceptance
  // --------------------------------------------------------------------------
  assign fetch_ready = (count_q <= CNT_W'(DEPTH_HW - HWB)) && !flush_i;
  assign beat_accept = bus.fetch_valid_i && fetch_ready;
  assign beat_off    = bus.fetch_addr_i[LB-1:1];
  assign beat_base   = {bus.fetch_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
  assign push_cnt    = CNT_W'(HWB) - CNT_W'(beat_off);
  assign discont     = beat_accept && !first_beat_q &&
                       (bus.fetch_addr_i != expect_addr_q);

  assign bus.fetch_ready_o = fetch_ready;
  assign occupancy_o       = count_q;

  always_comb begin
    hw_d          = hw_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    expect_addr_d = expect_addr_q;
    first_beat_d  = first_beat_q;
    slot          = '0;

    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      first_beat_d = 1'b1;
    end else begin
      if (inst_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(needed);
        count_d  = count_q - needed;
      end
      // Redirect without flush: drop everything older, including a lone
      // lower halfword still waiting for its partner.
      if (discont) begin
        rd_ptr_d = wr_ptr_q;
        count_d  = '0;
      end
      if (beat_accept) begin
        for (int i = 0; i < HWB; i++) begin
          if (i >= int'(beat_off)) begin
            slot          = wr_ptr_q + PTR_W'(i) - PTR_W'(beat_off);
            hw_d[slot]    = bus.fetch_data_i[16*i +: 16];
            pc_d[slot]    = beat_base + ADDR_W'(2 * i);
            fault_d[slot] = bus.fetch_fault_i;
          end
        end
        wr_ptr_d      = wr_ptr_q + PTR_W'(push_cnt);
        count_d       = count_d + push_cnt;
        expect_addr_d = beat_base + ADDR_W'(FETCH_W / 8);
        first_beat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q          <= '{default: '0};
      pc_q          <= '{default: '0};
      fault_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      expect_addr_q <= '0;
      first_beat_q  <= 1'b1;
    end else begin
      hw_q          <= hw_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      expect_addr_q <= expect_addr_d;
      first_beat_q  <= first_beat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef IFB_PERF_EN
  logic [31:0] perf_rvc_q, perf_rvc_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_rvc_d    = perf_rvc_q;
    perf_bubble_d = perf_bubble_q;
    if (inst_pop && head_rvc) begin
      perf_rvc_d = perf_rvc_q + 32'd1;
    end
    if (bus.inst_ready_i && !inst_valid && !flush_i) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rvc_q    <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_rvc_q    <= perf_rvc_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_rvc_cnt_o    = perf_rvc_q;
  assign perf_bubble_cnt_o = perf_bubble_q;
`else
  assign perf_rvc_cnt_o    = 32'd0;
  assign perf_bubble_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_align_buffer.sv
// ============================================================================
// Module   : tb_if_align_buffer
// Brief    : Directed, table-driven bench for if_align_buffer (FETCH_W=32,
//            DEPTH_HW=8). Counter expectations follow IFB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_align_buffer;

  localparam int FETCH_W  = 32;
  localparam int DEPTH_HW = 8;
  localparam int ADDR_W   = 32;
  localparam int OCC_W    = $clog2(DEPTH_HW + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      perf_rvc;
  logic [31:0]      perf_bubble;

  if_align_buffer_if #(.FETCH_W(FETCH_W), .ADDR_W(ADDR_W)) bus ();

  if_align_buffer #(
    .FETCH_W  (FETCH_W),
    .DEPTH_HW (DEPTH_HW),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (flush_i),
    .bus               (bus),
    .occupancy_o       (occupancy),
    .perf_rvc_cnt_o    (perf_rvc),
    .perf_bubble_cnt_o (perf_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        fv;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    logic        irdy;
    logic        ev;
    logic        efr;
    logic [3:0]  eocc;
    logic [31:0] epc;
    logic [31:0] edata;
    logic        erv;
    logic        eflt;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_rvc = 0;
  int   exp_bub = 0;

  task automatic add(input logic fl, input logic fv, input logic [31:0] a,
                     input logic [31:0] d, input logic ft, input logic ir,
                     input logic ev, input logic efr, input logic [3:0] occ,
                     input logic [31:0] pc, input logic [31:0] dat,
                     input logic rv, input logic efl);
    vec_t v;
    v.flush = fl;  v.fv = fv;   v.addr = a;    v.data = d;
    v.fault = ft;  v.irdy = ir; v.ev = ev;     v.efr = efr;
    v.eocc = occ;  v.epc = pc;  v.edata = dat; v.erv = rv;
    v.eflt = efl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [31:0] a,
                       input logic [31:0] d, input logic ft, input logic ir);
    flush_i           = fl;
    bus.fetch_valid_i = fv;
    bus.fetch_addr_i  = a;
    bus.fetch_data_i  = d;
    bus.fetch_fault_i = ft;
    bus.inst_ready_i  = ir;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // flush fv  addr          data          flt rdy | ev fr occ pc           data          rvc flt
    add(0, 0, 32'h0,        32'h0,        0, 0,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // aligned 32-bit
    add(0, 1, 32'h80000000, 32'h00500093, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // two RVC in one beat
    add(0, 1, 32'h80000000, 32'h45014581, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2, 32'h80000000, 32'h00004581, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 1, 32'h80000002, 32'h00004501, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // cross-beat 32-bit
    add(0, 1, 32'h80000002, 32'h00930000, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80000004, 32'h12340050, 0, 1,  0, 1, 1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 3, 32'h80000002, 32'h00500093, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 0,  1, 1, 1, 32'h80000006, 32'h00001234, 1, 0);
    add(1, 0, 32'h0,        32'h0,        0, 1,  0, 0, 1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 0,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // backpressure fill
    add(0, 1, 32'h80000000, 32'h00500093, 0, 0,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80000004, 32'h00500093, 0, 0,  1, 1, 2, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 1, 32'h80000008, 32'h00500093, 0, 0,  1, 1, 4, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 1, 32'h8000000C, 32'h00500093, 0, 0,  1, 1, 6, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 1, 32'h80000010, 32'h00000001, 0, 0,  1, 0, 8, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 1, 32'h80000010, 32'h00000001, 0, 1,  1, 0, 8, 32'h80000000, 32'h00500093, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 0,  1, 1, 6, 32'h80000004, 32'h00500093, 0, 0);
    add(1, 0, 32'h0,        32'h0,        0, 0,  0, 0, 6, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 0,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // flush with a lone lower halfword pending
    add(0, 1, 32'h80000002, 32'h00930000, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(1, 0, 32'h0,        32'h0,        0, 1,  0, 0, 1, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80001000, 32'h00500093, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2, 32'h80001000, 32'h00500093, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // fault on the upper-half beat
    add(0, 1, 32'h80000002, 32'h00930000, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80000004, 32'h12340050, 1, 1,  0, 1, 1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 3, 32'h80000002, 32'h00500093, 0, 1);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 1, 32'h80000006, 32'h00001234, 1, 1);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // discontinuity discards the lone halfword
    add(0, 1, 32'h80000002, 32'h00930000, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80002000, 32'h45014581, 0, 1,  0, 1, 1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2, 32'h80002000, 32'h00004581, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 1, 32'h80002002, 32'h00004501, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    // simultaneous push and pop
    add(0, 1, 32'h80002004, 32'h45014581, 0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h80002008, 32'h00500093, 0, 1,  1, 1, 2, 32'h80002004, 32'h00004581, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 3, 32'h80002006, 32'h00004501, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2, 32'h80002008, 32'h00500093, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1,  0, 1, 0, 32'h0,        32'h0,        0, 0);

    // reset state, observed while reset is held
    #2;
    chk("rst_valid", -1, 32'(bus.inst_valid_o),  32'd0);
    chk("rst_ready", -1, 32'(bus.fetch_ready_o), 32'd1);
    chk("rst_occ",   -1, 32'(occupancy),         32'd0);
    chk("rst_prvc",  -1, perf_rvc,               32'd0);
    chk("rst_pbub",  -1, perf_bubble,            32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].flush, vecs[i].fv, vecs[i].addr, vecs[i].data,
            vecs[i].fault, vecs[i].irdy);
      @(negedge clk);
      chk("valid", i, 32'(bus.inst_valid_o),  32'(vecs[i].ev));
      chk("fready", i, 32'(bus.fetch_ready_o), 32'(vecs[i].efr));
      chk("occ", i, 32'(occupancy), 32'(vecs[i].eocc));
      if (vecs[i].ev) begin
        chk("pc",    i, bus.inst_pc_o,             vecs[i].epc);
        chk("data",  i, bus.inst_data_o,           vecs[i].edata);
        chk("rvc",   i, 32'(bus.inst_is_rvc_o),    32'(vecs[i].erv));
        chk("fault", i, 32'(bus.inst_fault_o),     32'(vecs[i].eflt));
      end
      if (vecs[i].irdy && !vecs[i].flush && !vecs[i].ev) exp_bub++;
      if (vecs[i].irdy && vecs[i].ev && vecs[i].erv)     exp_rvc++;
    end

    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef IFB_PERF_EN
    chk("perf_rvc", -1, perf_rvc,    32'(exp_rvc));
    chk("perf_bub", -1, perf_bubble, 32'(exp_bub));
`else
    chk("perf_rvc", -1, perf_rvc,    32'd0);
    chk("perf_bub", -1, perf_bubble, 32'd0);
`endif

    // asynchronous reset in the middle of a stream
    @(posedge clk);
    #1 drive(0, 1, 32'h80003000, 32'h45014581, 0, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", -1, 32'(bus.inst_valid_o), 32'd1);
    chk("pre_rst_occ",   -1, 32'(occupancy),        32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", -1, 32'(bus.inst_valid_o),  32'd0);
    chk("async_occ",   -1, 32'(occupancy),         32'd0);
    chk("async_ready", -1, 32'(bus.fetch_ready_o), 32'd1);
    chk("async_prvc",  -1, perf_rvc,               32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // buffer is usable again after reset
    @(posedge clk);
    #1 drive(0, 1, 32'h80004000, 32'h00500093, 0, 1);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("post_rst_valid", -1, 32'(bus.inst_valid_o), 32'd1);
    chk("post_rst_pc",    -1, bus.inst_pc_o,         32'h80004000);
    chk("post_rst_data",  -1, bus.inst_data_o,       32'h00500093);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_occ",   -1, 32'(occupancy),        32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_align_buffer.md
Name: if_align_buffer

Overview:
- Parametrised fetch buffer and instruction aligner between the I-cache/MMU fetch path and the IF/ID register.
- Accepts fetch beats of FETCH_W bits, stores them as halfword entries, and emits one aligned instruction per handshake: 16-bit RVC or 32-bit, including 32-bit instructions that cross a beat boundary.
- Replaces the single-pending-halfword scheme with a DEPTH_HW-entry queue, valid/ready flow control, per-halfword fault tagging and flush.

Parameters:
- FETCH_W, 32, fetch beat width in bits; legal values 32 or 64.
- DEPTH_HW, 8, halfword queue entries; power of two, at least 2*FETCH_W/16.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect; discards all buffered state.
- fetch_valid_i  in  1  fetch beat valid.
- fetch_ready_o  out  1  buffer can accept a beat.
- fetch_addr_i  in  ADDR_W  byte address of the first wanted halfword; bit0 is 0.
- fetch_data_i  in  FETCH_W  beat data, naturally aligned to FETCH_W/8 bytes.
- fetch_fault_i  in  1  page/access fault for the whole beat.
- inst_valid_o  out  1  aligned instruction available.
- inst_ready_i  in  1  consumer takes the instruction.
- inst_pc_o  out  ADDR_W  PC of the instruction.
- inst_data_o  out  32  instruction; RVC is zero-extended, {16'b0, hw}.
- inst_is_rvc_o  out  1  instruction is compressed.
- inst_fault_o  out  1  fetch fault attached to the instruction.
- occupancy_o  out  $clog2(DEPTH_HW+1)  valid halfword entries.
- perf_rvc_cnt_o  out  32  see Optional Feature.
- perf_bubble_cnt_o  out  32  see Optional Feature.

Behaviour:
- Reset (rst_n=0, async): read/write pointers=0, count=0, expect_addr=0, first_beat=1. inst_valid_o=0, fetch_ready_o=1, occupancy_o=0. Perf counters=0. Reset mid-operation drops all entries immediately.
- Entry format: {hw[15:0], pc[ADDR_W-1:0], fault}.
- Beat accept requires fetch_valid_i & fetch_ready_o.
  - fetch_ready_o = (DEPTH_HW - count >= FETCH_W/16) & !flush_i.
  - off = fetch_addr_i[$clog2(FETCH_W/8)-1:1]. Halfwords below off are dropped. Halfwords off..FETCH_W/16-1 are pushed in ascending order with pc = beat base + 2*index, and fault = fetch_fault_i.
  - After a push, expect_addr = beat base + FETCH_W/8, and first_beat clears.
- Discontinuity: if an accepted beat has fetch_addr_i != expect_addr, first_beat=0 and flush_i=0, the queue is cleared and the new beat is pushed in the same cycle.
- Head decode (combinational from the queue, no bubble):
  - h0 = head entry; h1 = head+1.
  - RVC if h0.hw[1:0] != 2'b11; needs 1 entry.
  - Otherwise 32-bit; needs 2 entries; inst_data_o = {h1.hw, h0.hw}.
  - If h0.fault: emit with inst_fault_o=1, needing 1 entry.
  - Else if 32-bit and h1.fault: emit with inst_fault_o=1, pc=h0.pc, consuming 2 entries.
- inst_valid_o = (count >= needed) & !flush_i. inst_pc_o=h0.pc. Outputs are don't-care when not valid.
- Pop: inst_valid_o & inst_ready_i removes needed entries.
- Simultaneous push and pop in one cycle is legal: count += pushed - popped. Free space is checked before the pop, which is conservative.
- Latency: a beat accepted in cycle N yields inst_valid_o in cycle N+1. A 32-bit instruction whose upper half arrives in a later beat is emitted the cycle after that beat.
- Pointers wrap modulo DEPTH_HW. Count never exceeds DEPTH_HW.
- Flush has highest priority: in the cycle flush_i=1, no accept and no emit. At the next edge, count=0 and first_beat=1.
- Instruction data never aliases across a flush or discontinuity; a pending lone upper-less halfword is discarded.

Optional Feature:
- Macro IFB_PERF_EN.
- Defined:
  - perf_rvc_cnt_o increments on every popped RVC instruction.
  - perf_bubble_cnt_o increments on cycles with inst_ready_i=1, inst_valid_o=0, flush_i=0.
  - Both counters wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Aligned 32-bit (FETCH_W=32): beat addr 0x80000000, data 0x00500093 -> next cycle inst_valid_o=1, pc 0x80000000, data 0x00500093, rvc=0, occupancy 2->0 on pop.
- Two RVC in one beat: addr 0x80000000, data 0x45014581 -> pc 0x80000000 data 0x00004581 rvc=1, then pc 0x80000002 data 0x00004501 rvc=1.
- Cross-beat: beat1 addr 0x80000002, data 0x00930000 -> no inst_valid_o, occupancy 1; beat2 addr 0x80000004, data 0x12340050 -> pc 0x80000002, data 0x00500093, occupancy 1 after pop.
- Backpressure: inst_ready_i=0, four aligned beats -> occupancy 8, fetch_ready_o=0. One 32-bit pop -> fetch_ready_o=1 next cycle.
- Flush mid-cross: after beat1 of the cross-beat case, flush_i=1 -> occupancy 0. Beat addr 0x80001000, data 0x00500093 -> pc 0x80001000, correct data, no stale halfword.
- Fault and reset: cross-beat case with fetch_fault_i=1 on beat2 -> inst_fault_o=1, pc 0x80000002. Asserting rst_n=0 mid-stream -> inst_valid_o=0 and occupancy_o=0 immediately.
